// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Purpose : Shared digit-state encoding, active-high 7-segment codes and
//           binary-to-BCD helpers for the 2-digit count display.
// Revision: 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Which digit slot the scanner is currently driving
  typedef enum logic {
    DIG0 = 1'b0,  // units
    DIG1 = 1'b1   // tens
  } dig_state_e;

  // Active-high segment codes, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Tens digit of a 0..15 value: only ever 0 or 1
  function automatic logic [3:0] bcd_tens(input logic [3:0] v);
    return (v >= 4'd10) ? 4'd1 : 4'd0;
  endfunction

  // Units digit of a 0..15 value
  function automatic logic [3:0] bcd_units(input logic [3:0] v);
    return v - ((v >= 4'd10) ? 4'd10 : 4'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_dec.sv
`default_nettype none
// ============================================================================
// Module  : seg7_dec
// Purpose : Combinational decimal digit to active-high 7-segment decoder.
//           Non-decimal inputs (10..15) decode to a blank digit.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] code_o
);

  // Table lookup of the segment pattern for one digit
  always_comb begin
    code_o = SEG_BLANK;
    case (digit_i)
      4'd0:    code_o = SEG_0;
      4'd1:    code_o = SEG_1;
      4'd2:    code_o = SEG_2;
      4'd3:    code_o = SEG_3;
      4'd4:    code_o = SEG_4;
      4'd5:    code_o = SEG_5;
      4'd6:    code_o = SEG_6;
      4'd7:    code_o = SEG_7;
      4'd8:    code_o = SEG_8;
      4'd9:    code_o = SEG_9;
      default: code_o = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_cnt_disp.sv
`default_nettype none
// ============================================================================
// Module  : seg7_cnt_disp
// Purpose : Time-multiplexed 2-digit common-anode display of a 0..15 count.
//           The count is latched only at the end of a full units+tens scan so
//           both digits always belong to the same value.
//           Build option LEADING_ZERO_BLANK_EN: blank the tens slot when the
//           tens digit is zero (scan timing is unaffected).
// Revision: 1.0 - initial release
// ============================================================================
module seg7_cnt_disp
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       re,
  input  logic [3:0] val_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame
);

  // A 1-cycle slot still needs a 1-bit counter to keep the declarations legal
  localparam int             c_PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(REFRESH_DIV - 1);
  // XOR masks: applying them converts active-high patterns to pin polarity,
  // and on their own they are the "everything off" pin value
  localparam logic [6:0]     c_SEG_OFF   = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]     c_AN_OFF    = AN_ACT_LOW  ? 2'b11 : 2'b00;

  logic [c_PW-1:0] presc_q, presc_d;
  dig_state_e      state_q;
  logic [3:0]      hold_q;
  logic            frame_q;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      an_q, an_d;

  logic            w_tick;
  logic [3:0]      w_tens;
  logic [3:0]      w_units;
  logic [3:0]      w_digit;
  logic [6:0]      w_code;

  assign w_tick  = (presc_q == c_PRESC_MAX);
  assign presc_d = w_tick ? '0 : presc_q + 1'b1;

  assign w_tens  = bcd_tens(hold_q);
  assign w_units = bcd_units(hold_q);
  assign w_digit = (state_q == DIG0) ? w_units : w_tens;

  seg7_dec u_dec (
    .digit_i (w_digit),
    .code_o  (w_code)
  );

  // Prescaler, digit scan FSM and end-of-frame capture of the count
  always_ff @(posedge clk) begin
    if (re) begin
      presc_q <= '0;
      state_q <= DIG0;
      hold_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      frame_q <= 1'b0;
      if (w_tick) begin
        if (state_q == DIG0) begin
          state_q <= DIG1;
        end else begin
          state_q <= DIG0;
          hold_q  <= val_in;
          frame_q <= 1'b1;
        end
      end
    end
  end

  // Pin-level pattern for the slot currently being scanned
  always_comb begin
    seg_d = w_code ^ c_SEG_OFF;
    an_d  = ((state_q == DIG0) ? 2'b01 : 2'b10) ^ c_AN_OFF;
`ifdef LEADING_ZERO_BLANK_EN
    if ((state_q == DIG1) && (w_tens == 4'd0)) begin
      seg_d = c_SEG_OFF;
      an_d  = c_AN_OFF;
    end
`else
`endif
  end

  // Output registers; reset drives every segment and anode inactive
  always_ff @(posedge clk) begin
    if (re) begin
      seg_q <= c_SEG_OFF;
      an_q  <= c_AN_OFF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_cnt_disp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_seg7_cnt_disp
// Purpose : Directed self-checking bench for seg7_cnt_disp. One instance uses
//           a 4-cycle slot, a second one a 1-cycle slot. Expected pin values
//           are queued before each clock and compared after it.
//           Honours LEADING_ZERO_BLANK_EN for the tens-slot expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg7_cnt_disp;

  logic       clk = 1'b0;
  logic       re0, re1;
  logic [3:0] val0, val1;
  logic [6:0] seg0, seg1;
  logic [1:0] an0, an1;
  logic       frame0, frame1;

  seg7_cnt_disp #(.REFRESH_DIV(4), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) u_dut (
    .clk(clk), .re(re0), .val_in(val0), .seg(seg0), .an(an0), .frame(frame0)
  );

  seg7_cnt_disp #(.REFRESH_DIV(1), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) u_dut1 (
    .clk(clk), .re(re1), .val_in(val1), .seg(seg1), .an(an1), .frame(frame1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         k;
    bit         dut1;
    logic [9:0] exp;   // {seg, an, frame}
  } item_t;

  item_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  localparam logic [9:0] RST_OUT = {7'h7F, 2'b11, 1'b0};

  // Active-high reference patterns (gfedcba)
  function automatic logic [6:0] hcode(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [9:0] units_slot(input int v, input bit fr);
    return {~hcode(v % 10), 2'b10, fr};
  endfunction

  function automatic logic [9:0] tens_slot(input int v, input bit fr);
`ifdef LEADING_ZERO_BLANK_EN
    if ((v / 10) == 0) return {7'h7F, 2'b11, fr};
`endif
    return {~hcode(v / 10), 2'b01, fr};
  endfunction

  task automatic push(input string tag, input int k, input bit d1, input logic [9:0] e);
    item_t it;
    it.tag  = tag;
    it.k    = k;
    it.dut1 = d1;
    it.exp  = e;
    sb_q.push_back(it);
  endtask

  // Advance one clock, then compare the oldest queued expectation
  task automatic cyc_check();
    item_t      it;
    logic [9:0] obs;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: no expectation queued");
    end else begin
      it  = sb_q.pop_front();
      obs = it.dut1 ? {seg1, an1, frame1} : {seg0, an0, frame0};
      checks++;
      assert (obs === it.exp) else begin
        errors++;
        $error("FAIL %s[%0d]: seg/an/frame actual %h/%b/%b required %h/%b/%b",
               it.tag, it.k, obs[9:3], obs[2:1], obs[0],
               it.exp[9:3], it.exp[2:1], it.exp[0]);
      end
    end
  endtask

  // One 8-cycle frame of the 4-cycle-slot instance showing `shown`;
  // val_in moves after cycle 1 and again after cycle 5, only the last is captured
  task automatic run_frame(input string tag, input int shown,
                           input int v_early, input int v_late);
    for (int k = 1; k <= 8; k++) begin
      push(tag, k, 1'b0, (k <= 4) ? units_slot(shown, 1'b0) : tens_slot(shown, k == 8));
      cyc_check();
      if (k == 1) val0 = 4'(v_early);
      if (k == 5) val0 = 4'(v_late);
    end
  endtask

  initial begin
    logic [9:0] e;
    re0  = 1'b1;
    re1  = 1'b1;
    val0 = 4'd7;
    val1 = 4'd10;

    // Two reset cycles
    push("reset", 1, 1'b0, RST_OUT); cyc_check();
    push("reset", 2, 1'b0, RST_OUT); cyc_check();
    re0 = 1'b0;

    // First capture 8 cycles after release, then a sequence of values
    run_frame("first_00", 0, 7, 7);
    run_frame("show_07", 7, 12, 12);
    run_frame("show_12", 12, 15, 15);
    run_frame("show_15", 15, 3, 3);
    run_frame("show_03_chg9", 3, 3, 9);
    run_frame("show_09", 9, 4, 9);

    // Reset in the middle of the tens slot
    for (int k = 1; k <= 5; k++) begin
      push("pre_midreset", k, 1'b0, (k <= 4) ? units_slot(9, 1'b0) : tens_slot(9, 1'b0));
      cyc_check();
    end
    re0  = 1'b1;
    val0 = 4'd6;
    push("midreset", 6, 1'b0, RST_OUT); cyc_check();
    re0 = 1'b0;
    run_frame("after_reset_00", 0, 6, 6);
    run_frame("show_06", 6, 6, 6);

    // One-cycle slots: scan alternates every clock, frame every second clock
    push("div1_reset", 0, 1'b1, RST_OUT); cyc_check();
    re1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 1)           e = units_slot(0, 1'b0);
      else if (k == 2)      e = tens_slot(0, 1'b1);
      else if (k % 2 == 1)  e = units_slot(10, 1'b0);
      else                  e = tens_slot(10, 1'b1);
      push("div1", k, 1'b1, e);
      cyc_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
